// File: rtl/debug_dump_sequencer.sv
// Debug read-out sequencer for a halted pipeline. It streams the register file, then a
// data-memory window, then a snapshot of the pipeline latches, one byte at a time, into a TX FIFO.
module debug_dump_sequencer #(
  parameter int NB_REG      = 32,
  parameter int NB_R_INT    = 341,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 16,
  parameter int NB_MEM_ADDR = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [NB_REG-1:0]      i_reg_data,
  input  logic [NB_REG-1:0]      i_mem_data,
  input  logic [NB_R_INT-1:0]    i_latches_data,
  input  logic                   i_tx_full,
  output logic [4:0]             o_reg_addr,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_wr,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int WORD_BYTES = NB_REG / 8;
  localparam int LAT_BYTES  = (NB_R_INT + 7) / 8;
  localparam int LAT_W      = LAT_BYTES * 8;
  localparam int NB_CNT     = $clog2(((LAT_BYTES > WORD_BYTES) ? LAT_BYTES : WORD_BYTES) + 1);

  localparam logic [NB_CNT-1:0]      WORD_LAST = NB_CNT'(WORD_BYTES - 1);
  localparam logic [NB_CNT-1:0]      LAT_LAST  = NB_CNT'(LAT_BYTES - 1);
  localparam logic [4:0]             REG_LAST  = 5'(N_REGS - 1);
  localparam logic [NB_MEM_ADDR-1:0] MEM_LAST  = NB_MEM_ADDR'(N_MEM_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, REG_RD, REG_LD, REG_SEND, MEM_RD, MEM_LD, MEM_SEND, LAT_SEND, DONE
  } state_t;

  state_t              state;
  logic [NB_REG-1:0]   word_buf;
  logic [LAT_W-1:0]    lat_buf;
  logic [NB_CNT-1:0]   byte_cnt;
  logic                word_send;
  logic                in_dump;

  assign word_send = (state == REG_SEND) || (state == MEM_SEND);
  assign in_dump   = (state != IDLE) && (state != DONE);
  assign o_tx_wr   = (word_send || (state == LAT_SEND)) && !i_tx_full;

  // Outgoing byte is always the top byte of the active buffer, so it holds while the FIFO is full.
  always_comb begin
    o_tx_data = 8'd0;
    if (word_send)
      o_tx_data = word_buf[NB_REG-1 -: 8];
    else if (state == LAT_SEND)
      o_tx_data = lat_buf[LAT_W-1 -: 8];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      word_buf   <= '0;
      lat_buf    <= '0;
      byte_cnt   <= '0;
      o_reg_addr <= '0;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (in_dump && i_abort) begin
        state      <= IDLE;
        byte_cnt   <= '0;
        o_reg_addr <= '0;
        o_mem_addr <= '0;
        o_busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_start) begin
              lat_buf    <= LAT_W'(i_latches_data);
              byte_cnt   <= '0;
              o_reg_addr <= '0;
              o_mem_addr <= '0;
              o_busy     <= 1'b1;
              state      <= REG_RD;
            end
          end
          REG_RD: state <= REG_LD;
          REG_LD: begin
            word_buf <= i_reg_data;
            byte_cnt <= '0;
            state    <= REG_SEND;
          end
          REG_SEND: begin
            if (o_tx_wr) begin
              word_buf <= word_buf << 8;
              if (byte_cnt == WORD_LAST) begin
                byte_cnt <= '0;
                if (o_reg_addr == REG_LAST) begin
                  o_reg_addr <= '0;
                  state      <= MEM_RD;
                end else begin
                  o_reg_addr <= o_reg_addr + 5'd1;
                  state      <= REG_RD;
                end
              end else begin
                byte_cnt <= byte_cnt + NB_CNT'(1);
              end
            end
          end
          MEM_RD: state <= MEM_LD;
          MEM_LD: begin
            word_buf <= i_mem_data;
            byte_cnt <= '0;
            state    <= MEM_SEND;
          end
          MEM_SEND: begin
            if (o_tx_wr) begin
              word_buf <= word_buf << 8;
              if (byte_cnt == WORD_LAST) begin
                byte_cnt <= '0;
                if (o_mem_addr == MEM_LAST) begin
                  o_mem_addr <= '0;
                  state      <= LAT_SEND;
                end else begin
                  o_mem_addr <= o_mem_addr + NB_MEM_ADDR'(1);
                  state      <= MEM_RD;
                end
              end else begin
                byte_cnt <= byte_cnt + NB_CNT'(1);
              end
            end
          end
          LAT_SEND: begin
            if (o_tx_wr) begin
              lat_buf <= lat_buf << 8;
              if (byte_cnt == LAT_LAST) begin
                byte_cnt <= '0;
                o_busy   <= 1'b0;
                o_done   <= 1'b1;
                state    <= DONE;
              end else begin
                byte_cnt <= byte_cnt + NB_CNT'(1);
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: full dumps, FIFO backpressure, latch snapshot,
// abort, mid-dump reset and a held start request.
module tb_debug_dump_sequencer;

  logic         clk = 1'b0;
  logic         rst, start, abort, full;
  logic [31:0]  reg_data, mem_data;
  logic [340:0] latches;
  logic [4:0]   reg_addr, mem_addr;
  logic [7:0]   tx_data;
  logic         tx_wr, busy, done;

  logic [7:0]   byte_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  logic         prev_full = 1'b0;
  logic [7:0]   prev_data = 8'd0;
  bit           chk_stable = 1'b0;

  debug_dump_sequencer dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_reg_data(reg_data), .i_mem_data(mem_data), .i_latches_data(latches),
    .i_tx_full(full), .o_reg_addr(reg_addr), .o_mem_addr(mem_addr),
    .o_tx_data(tx_data), .o_tx_wr(tx_wr), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  // Register file and data memory with one-cycle read latency.
  always @(posedge clk) begin
    reg_data <= 32'h1000_0000 + 32'(reg_addr);
    mem_data <= 32'hA5A5_0000 + 32'(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte capture; a byte written right after a full cycle mid-word must equal the byte shown then.
  always @(negedge clk) begin
    if (tx_wr) begin
      if (chk_stable && prev_full && !((byte_q.size() % 4 == 0) && (byte_q.size() <= 192)))
        check($sformatf("stable%0d", byte_q.size()), 32'(tx_data), 32'(prev_data));
      byte_q.push_back(tx_data);
    end
    if (done) done_cnt++;
    prev_full = full;
    prev_data = tx_data;
  end

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    if (i < 128) begin
      w = 32'h1000_0000 + 32'(i / 4);
      return w[31 - 8 * (i % 4) -: 8];
    end else if (i < 192) begin
      w = 32'hA5A5_0000 + 32'((i - 128) / 4);
      return w[31 - 8 * ((i - 128) % 4) -: 8];
    end else if (i == 192) begin
      return 8'h1F;
    end
    return 8'hFF;
  endfunction

  task automatic check_bytes(input string tag, input int n);
    check({tag, "_count"}, 32'(byte_q.size()), 32'(n));
    for (int i = 0; i < byte_q.size() && i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(byte_q[i]), 32'(exp_byte(i)));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_tx_wr"},    32'(tx_wr),    32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Called just after a clock edge; runs one dump and checks bytes, done pulse and optionally timing.
  task automatic run_dump(input string tag, input int hold, input bit tog, input bit zlat,
                          input bit timed, input bit ab);
    int t;
    int done_t;
    int w;
    bit seen;
    byte_q.delete();
    done_cnt   = 0;
    chk_stable = tog;
    start      = 1'b1;
    abort      = ab;
    @(posedge clk); #1;
    t = 1; seen = 1'b0; done_t = 0;
    while (!seen && t < 3000) begin
      if (done) begin
        seen   = 1'b1;
        done_t = t;
      end else begin
        if (t >= hold) start = 1'b0;
        abort = 1'b0;
        if (zlat) latches = '0;
        full = tog ? t[0] : 1'b0;
        if (t == 1) check({tag, "_busy_on"}, 32'(busy), 32'd1);
        if (timed && t <= 288 && ((t - 1) % 6) < 2) begin
          w = (t - 1) / 6;
          if (w < 32) check($sformatf("%s_reg_addr_t%0d", tag, t), 32'(reg_addr), 32'(w));
          else        check($sformatf("%s_mem_addr_t%0d", tag, t), 32'(mem_addr), 32'(w - 32));
        end
        @(posedge clk); #1;
        t++;
      end
    end
    start = 1'b0; abort = 1'b0; full = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (timed) check({tag, "_done_latency"}, 32'(done_t), 32'd332);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk_stable = 1'b0;
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check_bytes(tag, 235);
    latches = '1;
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; full = 1'b0; latches = '1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Abort while idle does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);

    run_dump("plain", 1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_dump("bp_zlat", 1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Abort after ten bytes: the byte strobed in the abort cycle is the eleventh and last.
    byte_q.delete();
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (byte_q.size() < 10 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_wr", 32'(tx_wr), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check_bytes("abort", 11);

    // Restart after abort, with abort and start together in the idle cycle.
    run_dump("restart", 1, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the memory phase.
    byte_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (byte_q.size() < 130 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst = 1'b0;
    check("midreset_byte128", 32'(byte_q.size() > 128 ? byte_q[128] : 8'h00), 32'hA5);
    repeat (5) @(posedge clk);
    #1;
    check("midreset_stays_idle", 32'(busy), 32'd0);

    // Start held high for 40 cycles yields a single dump.
    run_dump("held", 40, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
